cva6_l2tlb_ctrl: RTL

Sequencing controller for the shared set-associative L2 TLB (4K-page bank) that sits behind the instruction and data L1 TLBs. It arbitrates L1-miss lookups from the ITLB and DTLB round-robin, issues array reads and returns hit/way results. It writes PTW refills using a round-robin victim way and performs full-array invalidation sweeps on sfence/hfence. The tag/data SRAM and comparators are external; this block owns only the sequencing, arbitration and counters.

---
 rtl/cva6_l2tlb_pkg.sv | 30 +++
 rtl/cva6_l2tlb_if.sv | 24 ++
 rtl/cva6_l2tlb_rr_arb.sv | 30 +++
 rtl/cva6_l2tlb_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cva6_l2tlb_pkg.sv
// Shared types and geometry helpers for the L2 TLB sequencing controller.
package cva6_l2tlb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    typedef enum logic {
        REQ_ITLB = 1'b0,
        REQ_DTLB = 1'b1
    } req_id_e;

    function automatic int unsigned set_bits(
        int unsigned entries,
        int unsigned assoc
    );
        return $clog2(entries / assoc);
    endfunction

    function automatic int unsigned tag_bits(
        int unsigned vpn_w,
        int unsigned entries,
        int unsigned assoc
    );
        return vpn_w - set_bits(entries, assoc);
    endfunction

endpackage

// File: rtl/cva6_l2tlb_if.sv
// Array access bus between the L2 TLB controller and the tag/data SRAM.
interface cva6_l2tlb_if #(
    parameter int unsigned Assoc = 4,
    parameter int unsigned SetW  = 5,
    parameter int unsigned TagW  = 22
) ();
    logic             req;
    logic             we;
    logic [SetW-1:0]  set;
    logic [TagW-1:0]  tag;
    logic [Assoc-1:0] way_we;
    logic             valid;
    logic [Assoc-1:0] hit;

    modport master (
        output req, we, set, tag, way_we, valid,
        input  hit
    );

    modport slave (
        input  req, we, set, tag, way_we, valid,
        output hit
    );
endinterface

// File: rtl/cva6_l2tlb_rr_arb.sv
// Two-input round-robin arbiter; the pointer names the requester that
// wins the next tie and flips to the other side after every grant.
module cva6_l2tlb_rr_arb
    import cva6_l2tlb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic r_rr;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (&req_i)
                gnt_o = (r_rr == REQ_DTLB) ? 2'b10 : 2'b01;
            else
                gnt_o = req_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_rr <= REQ_ITLB;
        else if (|gnt_o)
            r_rr <= gnt_o[0];
    end
endmodule

// File: rtl/cva6_l2tlb_ctrl.sv
// L2 TLB sequencer: lookup arbitration, PTW refill and invalidate sweeps.
// Define CVA6_L2TLB_PERF_EN to add saturating hit/miss counters.
module cva6_l2tlb_ctrl
    import cva6_l2tlb_pkg::*;
#(
    parameter int unsigned Entries  = 128,
    parameter int unsigned Assoc    = 4,
    parameter int unsigned VpnWidth = 27
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [1:0]                   req_i,
    input  logic [1:0][VpnWidth-1:0]     vpn_i,
    output logic [1:0]                   gnt_o,
    output logic                         resp_valid_o,
    output logic                         resp_id_o,
    output logic                         resp_hit_o,
    output logic [$clog2(Assoc)-1:0]     resp_way_o,
    input  logic                         refill_valid_i,
    output logic                         refill_ready_o,
    input  logic [VpnWidth-1:0]          refill_vpn_i,
    input  logic                         flush_i,
    output logic                         flush_ack_o,
`ifdef CVA6_L2TLB_PERF_EN
    output logic [31:0]                  hit_cnt_o,
    output logic [31:0]                  miss_cnt_o,
`endif
    cva6_l2tlb_if.master                 arr
);
    localparam int unsigned Sets    = Entries / Assoc;
    localparam int unsigned SetBits = set_bits(Entries, Assoc);
    localparam int unsigned TagBits = tag_bits(VpnWidth, Entries, Assoc);
    localparam int unsigned WayBits = $clog2(Assoc);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] RESP  = ST_RESP;
    localparam logic [1:0] FLUSH = ST_FLUSH;

    logic [1:0]         r_state;
    logic               r_flush_pend;
    logic [WayBits-1:0] r_victim;
    logic [SetBits-1:0] r_set;
    logic               r_id;

    logic                w_idle, w_resp, w_flushing, w_last;
    logic                w_refill_rdy, w_refill, w_lookup_en, w_go_flush;
    logic [1:0]          w_gnt;
    logic [VpnWidth-1:0] w_vpn;
    logic [WayBits-1:0]  w_way;

    // Outputs stay quiet while reset is held.
    assign w_idle       = (r_state == IDLE) & ~rst_i;
    assign w_resp       = (r_state == RESP) & ~rst_i;
    assign w_flushing   = (r_state == FLUSH) & ~rst_i;
    assign w_last       = (r_set == SetBits'(Sets - 1));
    assign w_refill_rdy = w_idle & ~r_flush_pend;
    assign w_refill     = w_refill_rdy & refill_valid_i;
    assign w_lookup_en  = w_refill_rdy & ~refill_valid_i;
    assign w_go_flush   = w_idle & r_flush_pend;
    assign w_vpn        = w_gnt[1] ? vpn_i[1] : vpn_i[0];

    cva6_l2tlb_rr_arb u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (w_lookup_en),
        .req_i (req_i),
        .gnt_o (w_gnt)
    );

    always_comb begin
        arr.req    = 1'b0;
        arr.we     = 1'b0;
        arr.set    = '0;
        arr.tag    = '0;
        arr.way_we = '0;
        arr.valid  = 1'b0;
        if (w_refill) begin
            arr.req    = 1'b1;
            arr.we     = 1'b1;
            arr.set    = refill_vpn_i[SetBits-1:0];
            arr.tag    = refill_vpn_i[SetBits +: TagBits];
            arr.way_we = Assoc'(1) << r_victim;
            arr.valid  = 1'b1;
        end else if (|w_gnt) begin
            arr.req = 1'b1;
            arr.set = w_vpn[SetBits-1:0];
            arr.tag = w_vpn[SetBits +: TagBits];
        end else if (w_flushing) begin
            arr.req    = 1'b1;
            arr.we     = 1'b1;
            arr.set    = r_set;
            arr.way_we = '1;
        end
    end

    // Lowest hitting way wins.
    always_comb begin
        w_way = '0;
        for (int i = Assoc - 1; i >= 0; i--)
            if (arr.hit[i]) w_way = WayBits'(i);
    end

    assign gnt_o          = w_gnt;
    assign refill_ready_o = w_refill_rdy;
    assign resp_valid_o   = w_resp;
    assign resp_id_o      = w_resp & r_id;
    assign resp_hit_o     = w_resp & (|arr.hit) & ~flush_i;
    assign resp_way_o     = w_resp ? w_way : '0;
    assign flush_ack_o    = w_flushing & w_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_flush_pend <= 1'b0;
            r_victim     <= '0;
            r_set        <= '0;
            r_id         <= REQ_ITLB;
        end else begin
            unique case (1'b1)
                w_go_flush: begin
                    r_state <= FLUSH;
                    r_set   <= '0;
                end
                (|w_gnt): begin
                    r_state <= RESP;
                    r_id    <= w_gnt[1];
                end
                (r_state == RESP):
                    r_state <= IDLE;
                (r_state == FLUSH): begin
                    r_set <= r_set + SetBits'(1);
                    if (w_last) r_state <= IDLE;
                end
                default: ;
            endcase
            // Pending is consumed on sweep entry, so a flush seen mid-sweep
            // survives and triggers another full sweep.
            r_flush_pend <= flush_i | (r_flush_pend & ~w_go_flush);
            if (w_refill) r_victim <= r_victim + WayBits'(1);
        end
    end

`ifdef CVA6_L2TLB_PERF_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_resp) begin
            if (resp_hit_o) begin
                if (~&r_hit_cnt) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                if (~&r_miss_cnt) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif
endmodule
